// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: state codes, opcode/funct
// values, ALU control codes and datapath mux encodings.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  // ALU operation class handed to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // State following DECODE; FETCH means the opcode is unsupported
  function automatic state_e decode_next(input logic [5:0] op);
    state_e nxt;
    case (op)
      OP_LW, OP_SW: nxt = S_MEMADR;
      OP_RTYPE:     nxt = S_EXEC;
      OP_BEQ:       nxt = S_BRANCH;
      OP_ADDI:      nxt = S_ADDIEX;
      OP_J:         nxt = S_JUMP;
      default:      nxt = S_FETCH;
    endcase
    decode_next = nxt;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU decoder: maps an operation class and R-type funct to the
// 3-bit ALU control code, flagging unsupported funct values.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_illegal
);

  always_comb begin
    alu_control   = ALU_ADD;
    funct_illegal = 1'b0;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: funct_illegal = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle MIPS datapath with a memory ready handshake,
// branch resolution and a retired-instruction counter.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 pc_en,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic                 reg_dest,
  output logic                 mem_to_reg,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           alu_control,
  output logic                 instr_done,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic [3:0]           state
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] instr_count_q, instr_count_d;
  logic [1:0]           alu_op;
  logic                 alu_en;
  logic [2:0]           dec_alu_control;
  logic                 funct_illegal;

  // ALU class depends only on the state, keeping the decoder out of any loop
  always_comb begin
    alu_op = ALUOP_ADD;
    case (state_q)
      S_EXEC, S_ALUWB: alu_op = ALUOP_FUNCT;
      S_BRANCH:        alu_op = ALUOP_SUB;
      default:         alu_op = ALUOP_ADD;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op        (alu_op),
    .funct         (funct),
    .alu_control   (dec_alu_control),
    .funct_illegal (funct_illegal)
  );

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = PCSRC_ALU;
    reg_write  = 1'b0;
    reg_dest   = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RD2;
    alu_en     = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_en    = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_en    = 1'b1;
        state_d   = decode_next(opcode);
        if (state_d == S_FETCH) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_en    = 1'b1;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_en    = 1'b1;
        illegal   = funct_illegal;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = !funct_illegal;
        reg_dest   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_en     = 1'b1;
        pc_src     = PCSRC_ALUOUT;
        pc_en      = zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_en    = 1'b1;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = PCSRC_JUMP;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset silences the datapath immediately so an abandoned instruction writes nothing
    if (rst) begin
      state_d    = S_FETCH;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      pc_src     = PCSRC_ALU;
      reg_write  = 1'b0;
      reg_dest   = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_RD2;
      alu_en     = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end

    instr_count_d = instr_count_q + {{(CNT_WIDTH-1){1'b0}}, instr_done};
  end

  assign alu_control = alu_en ? dec_alu_control : 3'b000;
  assign state       = rst ? 4'd0 : state_q;
  assign instr_count = rst ? '0 : instr_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into an
// expected per-cycle trace from the instruction-level rules and compared cycle by cycle.
module tb_multicycle_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    opcode, funct;
  logic          zero, mem_ready;
  logic          mem_req, mem_write, i_or_d, ir_write, pc_en;
  logic [1:0]    pc_src;
  logic          reg_write, reg_dest, mem_to_reg, alu_src_a;
  logic [1:0]    alu_src_b;
  logic [2:0]    alu_control;
  logic          instr_done, illegal;
  logic [CW-1:0] instr_count;
  logic [3:0]    state;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .i_or_d(i_or_d), .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dest(reg_dest), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .instr_done(instr_done), .illegal(illegal), .instr_count(instr_count),
    .state(state)
  );

  typedef struct packed {
    logic       mem_req, mem_write, i_or_d, ir_write, pc_en;
    logic [1:0] pc_src;
    logic       reg_write, reg_dest, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       instr_done, illegal;
  } out_t;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    out_t       o;
  } ent_t;

  out_t got_o;
  assign got_o = {mem_req, mem_write, i_or_d, ir_write, pc_en, pc_src, reg_write,
                  reg_dest, mem_to_reg, alu_src_a, alu_src_b, alu_control,
                  instr_done, illegal};

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [CW-1:0] exp_cnt;
  ent_t          tr[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
  endtask

  // R-type semantics: {illegal, alu code}
  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: r_alu = {1'b0, 3'b010};
      6'b100010: r_alu = {1'b0, 3'b110};
      6'b100100: r_alu = {1'b0, 3'b000};
      6'b100101: r_alu = {1'b0, 3'b001};
      6'b101010: r_alu = {1'b0, 3'b111};
      default:   r_alu = {1'b1, 3'b010};
    endcase
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy, input out_t o);
    ent_t e;
    e.st = st; e.rdy = rdy; e.o = o;
    tr.push_back(e);
  endtask

  // A memory phase: `waits` not-ready cycles, then the completing cycle
  task automatic push_mem(input logic [3:0] st, input out_t ow, input out_t od, input int waits);
    for (int i = 0; i < waits; i++) push(st, 1'b0, ow);
    push(st, 1'b1, od);
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    out_t o, od;
    logic [3:0] ra;
    tr.delete();
    o = '0; o.mem_req = 1; o.alu_src_b = 2'b01; o.alu_control = 3'b010;
    od = o; od.ir_write = 1; od.pc_en = 1;
    push_mem(4'd0, o, od, fw);
    o = '0; o.alu_src_b = 2'b11; o.alu_control = 3'b010;
    if (!(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010})) begin
      o.illegal = 1; o.instr_done = 1;
      push(4'd1, 1'($urandom_range(0, 1)), o);
      return;
    end
    push(4'd1, 1'($urandom_range(0, 1)), o);
    case (op)
      6'b100011, 6'b101011: begin
        o = '0; o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_control = 3'b010;
        push(4'd2, 1'($urandom_range(0, 1)), o);
        if (op == 6'b100011) begin
          o = '0; o.mem_req = 1; o.i_or_d = 1;
          push_mem(4'd3, o, o, mw);
          o = '0; o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1;
          push(4'd4, 1'($urandom_range(0, 1)), o);
        end else begin
          o = '0; o.mem_req = 1; o.mem_write = 1; o.i_or_d = 1;
          od = o; od.instr_done = 1;
          push_mem(4'd5, o, od, mw);
        end
      end
      6'b000000: begin
        ra = r_alu(fn);
        o = '0; o.alu_src_a = 1; o.alu_control = ra[2:0]; o.illegal = ra[3];
        push(4'd6, 1'($urandom_range(0, 1)), o);
        o = '0; o.reg_write = !ra[3]; o.reg_dest = 1; o.instr_done = 1;
        push(4'd7, 1'($urandom_range(0, 1)), o);
      end
      6'b000100: begin
        o = '0; o.alu_src_a = 1; o.alu_control = 3'b110; o.pc_src = 2'b01;
        o.pc_en = zero; o.instr_done = 1;
        push(4'd8, 1'($urandom_range(0, 1)), o);
      end
      6'b001000: begin
        o = '0; o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_control = 3'b010;
        push(4'd9, 1'($urandom_range(0, 1)), o);
        o = '0; o.reg_write = 1; o.instr_done = 1;
        push(4'd10, 1'($urandom_range(0, 1)), o);
      end
      default: begin
        o = '0; o.pc_src = 2'b10; o.pc_en = 1; o.instr_done = 1;
        push(4'd11, 1'($urandom_range(0, 1)), o);
      end
    endcase
  endtask

  // Entered and left at posedge+1; samples at posedge+3
  task automatic run(input string name, input int limit);
    int n;
    n = 0;
    for (int i = 0; i < tr.size() && i < limit; i++) begin
      mem_ready = tr[i].rdy;
      #2;
      check_eq($sformatf("%s.c%0d.state", name, i), 32'(state), 32'(tr[i].st));
      check_eq($sformatf("%s.c%0d.outs", name, i), 32'(got_o), 32'(tr[i].o));
      check_eq($sformatf("%s.c%0d.count", name, i), 32'(instr_count), 32'(exp_cnt));
      if (tr[i].o.instr_done) exp_cnt = exp_cnt + 1'b1;
      n++;
      @(posedge clk); #1;
    end
    $display("txn %s op=%b fn=%b zero=%b cycles=%0d count=%0d", name, opcode, funct, zero, n, exp_cnt);
  endtask

  task automatic do_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input int fw, input int mw);
    opcode = op; funct = fn; zero = z;
    build(op, fn, fw, mw);
    run(name, 1000);
  endtask

  logic [5:0] r_fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [5:0] kinds [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

  initial begin
    logic [5:0] op, fn;
    rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    #2;
    check_eq("rst.state", 32'(state), 32'd0);
    check_eq("rst.outs", 32'(got_o), 32'd0);
    check_eq("rst.count", 32'(instr_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = '0;

    do_instr("lw", 6'b100011, 6'd0, 1'b0, 0, 0);
    do_instr("sw_wait3", 6'b101011, 6'd0, 1'b0, 0, 3);
    do_instr("beq_z1", 6'b000100, 6'd0, 1'b1, 0, 0);
    do_instr("beq_z0", 6'b000100, 6'd0, 1'b0, 0, 0);
    for (int k = 0; k < 5; k++) do_instr($sformatf("r_fn%0d", k), 6'b000000, r_fns[k], 1'b0, 0, 0);
    do_instr("r_illegal_fn", 6'b000000, 6'b000111, 1'b0, 0, 0);
    do_instr("illegal_op", 6'b111111, 6'd0, 1'b0, 0, 0);
    do_instr("addi", 6'b001000, 6'd0, 1'b0, 0, 0);
    do_instr("j", 6'b000010, 6'd0, 1'b0, 0, 0);

    // Reset while waiting in MEMRD: fetch(1 wait + ready), decode, memadr, then MEMRD
    opcode = 6'b100011; funct = '0; zero = 1'b0;
    build(6'b100011, 6'd0, 1, 2);
    run("lw_cut", 4);
    rst = 1'b1; mem_ready = 1'b1;
    #2;
    check_eq("rst_mid.state", 32'(state), 32'd0);
    check_eq("rst_mid.outs", 32'(got_o), 32'd0);
    check_eq("rst_mid.count", 32'(instr_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; exp_cnt = '0; mem_ready = 1'b0;
    #2;
    check_eq("after_rst.state", 32'(state), 32'd0);
    check_eq("after_rst.count", 32'(instr_count), 32'd0);
    @(posedge clk); #1;

    // Random instruction mix; the 4-bit counter wraps several times
    for (int t = 0; t < 80; t++) begin
      int kind;
      kind = $urandom_range(0, 6);
      op = (kind == 6) ? 6'($urandom) : kinds[kind];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : r_fns[$urandom_range(0, 4)];
      do_instr($sformatf("rnd%0d", t), op, fn, 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
